// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Upstream command stage for the 8-bit PowerALU. Commands {sel, A, B} are
// buffered in a small FIFO. They are issued one at a time to the ALU's
// registered operand inputs. The ALU's combinational output is captured
// into a result register that has its own valid/ready handshake.
//
// Optional build macro: ALU_SEQ_ZERO_FLAG_EN
//   When defined, adds output res_zero. It is registered alongside res_data
//   and is high when the captured ALU output was zero.
//
// FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no command in flight; pop the FIFO head as soon as count > 0
//   ST_EXEC | operands stable for one full cycle; capture alu_out at edge
//   ST_WAIT | result held on res_*; wait for res_ready, then pop or idle

module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int SW    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [SW-1:0]           cmd_sel,
    input  logic [W-1:0]            cmd_a,
    input  logic [W-1:0]            cmd_b,
    output logic [SW-1:0]           alu_s,
    output logic [W-1:0]            alu_a,
    output logic [W-1:0]            alu_b,
    input  logic [W-1:0]            alu_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [W-1:0]            res_data,
    output logic [SW-1:0]           res_sel,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic                    res_zero,
`endif
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = SW + 2 * W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           push;
    logic           pop;
    logic           fifo_nonempty;
    logic [SW-1:0]  head_sel;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;

    // ------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------
    state_t         state_q;
    logic [SW-1:0]  alu_s_q;
    logic [W-1:0]   alu_a_q;
    logic [W-1:0]   alu_b_q;
    logic           res_valid_q;
    logic [W-1:0]   res_data_q;
    logic [SW-1:0]  res_sel_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic           res_zero_q;
`endif

    // Ready is decoded from the registered count only, so a pop in the
    // same cycle never lets a push slip into a full FIFO.
    assign cmd_ready     = (count_q < FULL_CNT);
    assign push          = cmd_valid & cmd_ready;
    assign fifo_nonempty = (count_q != '0);

    // The FSM consumes the head when idle, or when the held result is
    // being accepted and another command is waiting.
    assign pop = fifo_nonempty &
                 ((state_q == ST_IDLE) |
                  ((state_q == ST_WAIT) & res_valid_q & res_ready));

    assign {head_sel, head_a, head_b} = mem_q[rd_ptr_q];

    // Next-state for FIFO pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers and storage write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {cmd_sel, cmd_a, cmd_b};
            end
        end
    end

    // Issue/capture sequencer with registered ALU operands and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_s_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            res_zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Operands keep their last value while idle.
                    if (fifo_nonempty) begin
                        alu_s_q <= head_sel;
                        alu_a_q <= head_a;
                        alu_b_q <= head_b;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_data_q  <= alu_out;
                    res_sel_q   <= alu_s_q;
                    res_valid_q <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    res_zero_q  <= (alu_out == '0);
`endif
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (res_valid_q && res_ready) begin
                        res_valid_q <= 1'b0;
                        if (fifo_nonempty) begin
                            alu_s_q <= head_sel;
                            alu_a_q <= head_a;
                            alu_b_q <= head_b;
                            state_q <= ST_EXEC;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_s     = alu_s_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_sel   = res_sel_q;
    assign count     = count_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign res_zero  = res_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer. It models the external ALU
// combinationally and scoreboards expected results in command order.
// Build with ALU_SEQ_ZERO_FLAG_EN defined to also check res_zero.

module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int SW    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [SW-1:0]  cmd_sel;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic [SW-1:0]  alu_s;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_out;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic [SW-1:0]  res_sel;
    logic [CW-1:0]  count;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic           res_zero;
`endif

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
    } cmd_t;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [W-1:0]  data;
    } exp_t;

    cmd_t src_q[$];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rr_mode  = 1;   // 0: res_ready low, 1: high, 2: random

    logic           hold_pend = 1'b0;
    logic [W-1:0]   hold_data;
    logic [SW-1:0]  hold_sel;
    logic [W-1:0]   hold_opa;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sel   (res_sel),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .res_zero  (res_zero),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU used both as the DUT's environment and for expectations.
    function automatic logic [7:0] ref_alu(input logic [3:0] s,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        case (s)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~a;
            4'h6: return {a[6:0], 1'b0};
            4'h7: return {1'b0, a[7:1]};
            4'h8: return a + 8'd1;
            4'h9: return a - 8'd1;
            4'hA: return {a[6:0], a[7]};
            4'hB: return b;
            4'hC: return a + b + 8'd1;
            4'hD: return ~(a & b);
            4'hE: return a - b;
            default: return a;
        endcase
    endfunction

    always_comb alu_out = ref_alu(alu_s, alu_a, alu_b);

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at the falling edge, evaluate handshakes that will
    // happen at the next rising edge, then advance to the next falling edge.
    task automatic tick();
        exp_t e;
        if (src_q.size() != 0) begin
            cmd_valid = 1'b1;
            cmd_sel   = src_q[0].sel;
            cmd_a     = src_q[0].a;
            cmd_b     = src_q[0].b;
        end else begin
            cmd_valid = 1'b0;
        end
        case (rr_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (hold_pend) begin
            check_eq("hold_valid", 32'(res_valid), 32'(1));
            check_eq("hold_data",  32'(res_data),  32'(hold_data));
            check_eq("hold_sel",   32'(res_sel),   32'(hold_sel));
            check_eq("hold_opa",   32'(alu_a),     32'(hold_opa));
        end
        if (cmd_valid && cmd_ready) begin
            e.sel  = cmd_sel;
            e.data = ref_alu(cmd_sel, cmd_a, cmd_b);
            exp_q.push_back(e);
            void'(src_q.pop_front());
        end
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_res", 32'(res_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("res_data", 32'(res_data), 32'(e.data));
                check_eq("res_sel",  32'(res_sel),  32'(e.sel));
`ifdef ALU_SEQ_ZERO_FLAG_EN
                check_eq("res_zero", 32'(res_zero), 32'(e.data == '0));
`endif
            end
        end
        hold_pend = res_valid && !res_ready;
        hold_data = res_data;
        hold_sel  = res_sel;
        hold_opa  = alu_a;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (src_q.size() == 0 && exp_q.size() == 0 && !res_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check_eq("drain_done", 32'(done), 32'(1));
    endtask

    task automatic push_cmd(input logic [3:0] s, input logic [7:0] a,
                            input logic [7:0] b);
        cmd_t c;
        c.sel = s;
        c.a   = a;
        c.b   = b;
        src_q.push_back(c);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_count"},  32'(count),     32'(0));
        check_eq({tag, "_ready"},  32'(cmd_ready), 32'(1));
        check_eq({tag, "_alu_s"},  32'(alu_s),     32'(0));
        check_eq({tag, "_alu_a"},  32'(alu_a),     32'(0));
        check_eq({tag, "_alu_b"},  32'(alu_b),     32'(0));
        check_eq({tag, "_rvalid"}, 32'(res_valid), 32'(0));
        check_eq({tag, "_rdata"},  32'(res_data),  32'(0));
        check_eq({tag, "_rsel"},   32'(res_sel),   32'(0));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check_eq({tag, "_rzero"},  32'(res_zero),  32'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout reached @%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_rst");

        // Single command latency: push at edge N, pop at N+1, result at N+2.
        rr_mode = 1;
        push_cmd(4'h0, 8'h65, 8'h3E);
        tick();
        check_eq("lat_count_n",  32'(count),     32'(1));
        check_eq("lat_valid_n",  32'(res_valid), 32'(0));
        tick();
        check_eq("lat_alu_s",    32'(alu_s),     32'(0));
        check_eq("lat_alu_a",    32'(alu_a),     32'(8'h65));
        check_eq("lat_alu_b",    32'(alu_b),     32'(8'h3E));
        check_eq("lat_count_n1", 32'(count),     32'(0));
        check_eq("lat_valid_n1", 32'(res_valid), 32'(0));
        tick();
        check_eq("lat_valid_n2", 32'(res_valid), 32'(1));
        check_eq("lat_data",     32'(res_data),  32'(8'hA3));
        check_eq("lat_sel",      32'(res_sel),   32'(0));
        drain(20);

        // Fill with consumer stalled, then release; full+pop keeps 4/3/4/3.
        rr_mode = 0;
        for (int i = 0; i < 9; i++) begin
            push_cmd(4'(i + 1), 8'(8'h10 * i + 3), 8'(8'h21 + i));
        end
        repeat (8) tick();
        check_eq("full_count",   32'(count),        32'(4));
        check_eq("full_ready",   32'(cmd_ready),    32'(0));
        check_eq("full_pending", 32'(src_q.size()), 32'(4));
        check_eq("full_rvalid",  32'(res_valid),    32'(1));
        rr_mode = 1;
        tick();
        check_eq("wrap_cnt_a", 32'(count), 32'(3));
        tick();
        check_eq("wrap_cnt_b", 32'(count), 32'(4));
        tick();
        check_eq("wrap_cnt_c", 32'(count), 32'(3));
        tick();
        check_eq("wrap_cnt_d", 32'(count), 32'(4));
        drain(100);

        // Random back-pressure over 12 commands, all select codes possible.
        rr_mode = 2;
        push_cmd(4'hC, 8'hFF, 8'hFE);
        push_cmd(4'hD, 8'hA7, 8'hFC);
        for (int i = 0; i < 10; i++) begin
            push_cmd(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
        end
        drain(400);

        // Zero-result commands.
        rr_mode = 2;
        push_cmd(4'hE, 8'h1A, 8'h1A);
        push_cmd(4'hE, 8'h1A, 8'h1B);
        push_cmd(4'hE, 8'h1A, 8'h1A);
        push_cmd(4'h2, 8'hF0, 8'h0F);
        drain(200);

        // Asynchronous reset while a result waits and three are queued.
        rr_mode = 0;
        push_cmd(4'h3, 8'h11, 8'h22);
        push_cmd(4'h4, 8'h33, 8'h44);
        push_cmd(4'h5, 8'h55, 8'h66);
        push_cmd(4'h6, 8'h77, 8'h88);
        repeat (8) tick();
        check_eq("prerst_count",  32'(count),     32'(3));
        check_eq("prerst_rvalid", 32'(res_valid), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        src_q.delete();
        exp_q.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rr_mode = 1;
        repeat (6) tick();
        check_eq("postrst_rvalid", 32'(res_valid), 32'(0));
        check_eq("postrst_count",  32'(count),     32'(0));
        push_cmd(4'h7, 8'h80, 8'h00);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
